// File: rtl/ps2_scancode_rx_if.sv
// ps2_scancode_rx_if
// Scan-code delivery bus between the PS/2 receive front end and the game
// core's input decoder.
//   SCAN_VALID : one-cycle strobe, SCAN_CODE holds a new good byte
//   SCAN_CODE  : last good byte, held between strobes
//   FRAME_ERR  : one-cycle strobe on parity/start/stop/timeout failure
//   KEY_EXT    : E0 prefix preceded this byte (0 unless prefix decode built)
//   KEY_BREAK  : F0 prefix preceded this byte (0 unless prefix decode built)
// Modports: master = receiver (drives the bus), slave = consumer.
`timescale 1ns/1ps

interface ps2_scancode_rx_if;
  logic       SCAN_VALID;
  logic [7:0] SCAN_CODE;
  logic       FRAME_ERR;
  logic       KEY_EXT;
  logic       KEY_BREAK;

  modport master (
    output SCAN_VALID,
    output SCAN_CODE,
    output FRAME_ERR,
    output KEY_EXT,
    output KEY_BREAK
  );

  modport slave (
    input SCAN_VALID,
    input SCAN_CODE,
    input FRAME_ERR,
    input KEY_EXT,
    input KEY_BREAK
  );
endinterface

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx
// PS/2 keyboard receive front end. Synchronises and deglitches the raw
// PS2_CLK/PS2_DATA pins, deframes 11-bit device-to-host frames (start,
// 8 data LSB first, odd parity, stop) and delivers each good byte as a
// one-cycle strobe in the 25 MHz domain. Receive-only.
// Ports:
//   CLK_25MHZ : system clock (single domain)
//   RESET     : synchronous, active-high reset
//   PS2_CLK   : raw PS/2 clock pin, asynchronous
//   PS2_DATA  : raw PS/2 data pin, asynchronous
//   scan_bus  : ps2_scancode_rx_if.master (SCAN_VALID, SCAN_CODE,
//               FRAME_ERR, KEY_EXT, KEY_BREAK)
// Parameters:
//   FILTER_LEN     : consecutive equal samples before the filtered clock
//                    changes state (2..15)
//   TIMEOUT_CYCLES : cycles allowed between falls inside a frame
// Optional feature macro: PS2_PREFIX_DECODE_EN
//   Defined   : E0/F0 prefixes are absorbed into sticky flags and reported
//               on KEY_EXT/KEY_BREAK with the following byte.
//   Undefined : every good byte is emitted raw; KEY_EXT/KEY_BREAK tied 0.
`timescale 1ns/1ps

module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                  CLK_25MHZ,
  input  logic                  RESET,
  input  logic                  PS2_CLK,
  input  logic                  PS2_DATA,
  ps2_scancode_rx_if.master     scan_bus
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic            clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
  logic [3:0]      filt_cnt_q, filt_cnt_d;
  logic            filt_clk_q, filt_clk_d;
  logic            filt_prev_q;
  logic            fall;
  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            good_byte;
  logic            frame_err_d, frame_err_q;
  logic            scan_valid_d, scan_valid_q;
  logic [7:0]      scan_code_d, scan_code_q;

  // The filtered clock only follows the synchronised pin once it has
  // disagreed for FILTER_LEN samples in a row; any agreement restarts it.
  always_comb begin
    filt_cnt_d = '0;
    filt_clk_d = filt_clk_q;
    if (clk_sync_q != filt_clk_q) begin
      if (filt_cnt_q == 4'(FILTER_LEN - 1)) begin
        filt_clk_d = clk_sync_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 4'd1;
      end
    end
  end

  assign fall = filt_prev_q & ~filt_clk_q;

  // Frame deframing and inter-edge timeout. A fall always takes priority
  // over the timeout so a late-but-valid edge is never discarded.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    to_cnt_d    = to_cnt_q;
    good_byte   = 1'b0;
    frame_err_d = 1'b0;

    if (state_q == IDLE || fall) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
      to_cnt_d    = '0;
      state_d     = IDLE;
      frame_err_d = 1'b1;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    if (fall) begin
      case (state_q)
        IDLE: begin
          if (!data_sync_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            shift_d   = '0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        DATA: begin
          shift_d[bit_cnt_q] = data_sync_q;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          parity_d = data_sync_q;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (data_sync_q && ((^shift_q) ^ parity_q)) begin
            good_byte = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef PS2_PREFIX_DECODE_EN
  logic ext_q, ext_d, brk_q, brk_d;
  logic key_ext_q, key_ext_d, key_break_q, key_break_d;

  // Prefix bytes are swallowed into sticky flags; the next real byte
  // carries them out and clears them. Any frame error drops them.
  always_comb begin
    scan_valid_d = 1'b0;
    scan_code_d  = scan_code_q;
    ext_d        = ext_q;
    brk_d        = brk_q;
    key_ext_d    = key_ext_q;
    key_break_d  = key_break_q;
    if (good_byte) begin
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        scan_valid_d = 1'b1;
        scan_code_d  = shift_q;
        key_ext_d    = ext_q;
        key_break_d  = brk_q;
        ext_d        = 1'b0;
        brk_d        = 1'b0;
      end
    end
    if (frame_err_d) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

  always_ff @(posedge CLK_25MHZ) begin
    if (RESET) begin
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      key_ext_q   <= 1'b0;
      key_break_q <= 1'b0;
    end else begin
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      key_ext_q   <= key_ext_d;
      key_break_q <= key_break_d;
    end
  end

  assign scan_bus.KEY_EXT   = key_ext_q;
  assign scan_bus.KEY_BREAK = key_break_q;
`else
  // Without prefix decoding every good byte goes straight out.
  always_comb begin
    scan_valid_d = good_byte;
    scan_code_d  = good_byte ? shift_q : scan_code_q;
  end

  assign scan_bus.KEY_EXT   = 1'b0;
  assign scan_bus.KEY_BREAK = 1'b0;
`endif

  // State registers; pins come in through two-flop synchronisers that
  // idle high like the bus itself.
  always_ff @(posedge CLK_25MHZ) begin
    if (RESET) begin
      clk_meta_q   <= 1'b1;
      clk_sync_q   <= 1'b1;
      data_meta_q  <= 1'b1;
      data_sync_q  <= 1'b1;
      filt_cnt_q   <= '0;
      filt_clk_q   <= 1'b1;
      filt_prev_q  <= 1'b1;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      to_cnt_q     <= '0;
      frame_err_q  <= 1'b0;
      scan_valid_q <= 1'b0;
      scan_code_q  <= '0;
    end else begin
      clk_meta_q   <= PS2_CLK;
      clk_sync_q   <= clk_meta_q;
      data_meta_q  <= PS2_DATA;
      data_sync_q  <= data_meta_q;
      filt_cnt_q   <= filt_cnt_d;
      filt_clk_q   <= filt_clk_d;
      filt_prev_q  <= filt_clk_q;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      to_cnt_q     <= to_cnt_d;
      frame_err_q  <= frame_err_d;
      scan_valid_q <= scan_valid_d;
      scan_code_q  <= scan_code_d;
    end
  end

  assign scan_bus.SCAN_VALID = scan_valid_q;
  assign scan_bus.SCAN_CODE  = scan_code_q;
  assign scan_bus.FRAME_ERR  = frame_err_q;

endmodule
